// File: rtl/ptw_read_resp_pkg.sv
// Shared definitions for the page-table-walk read responder.
package ptw_read_resp_pkg;

  // Register tag the pager places on the mOp bus for walker reads.
  localparam logic [8:0] PTW_WALK_TAG = 9'h1fc;

  // One queued walk read: 16-byte-aligned physical address bits [43:4].
  localparam int PTW_ENTRY_WIDTH = 40;
  typedef logic [PTW_ENTRY_WIDTH-1:0] ptw_entry_t;

  // Responder FSM encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/ptw_req_fifo.sv
// DEPTH-entry synchronous request FIFO with flush and a registered
// almost-full flag used as bus back-pressure.
module ptw_req_fifo
  import ptw_read_resp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = PTW_ENTRY_WIDTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          almost_full
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          almost_full_q, almost_full_d;

  // Next pointers/count; flush empties the queue on the same edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    // Asserted one early so the op already in flight past the hold still fits.
    almost_full_d = (count_d >= CW'(DEPTH - 1));
  end

  // Control state.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      almost_full_q <= almost_full_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count/pointers alone define which entries are valid.
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head        = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign almost_full = almost_full_q;

endmodule

// File: rtl/ptw_read_resp.sv
// Responder for page-walker read micro-ops: queues tagged ops, issues one
// 128-bit memory read at a time and returns each result as a FUHit pulse.
module ptw_read_resp
  import ptw_read_resp_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int REG_WIDTH   = 9,
  parameter int PADDR_WIDTH = 44,
  parameter logic [REG_WIDTH-1:0] WALK_TAG = REG_WIDTH'(PTW_WALK_TAG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   req_bus,
  input  logic                   mOp_en,
  input  logic [REG_WIDTH-1:0]   mOp_register,
  input  logic [PADDR_WIDTH-9:0] mOp_addrEven,
  input  logic [PADDR_WIDTH-9:0] mOp_addrOdd,
  input  logic                   mOp_odd,
  input  logic [4:0]             mOp_bank0,
  output logic                   bus_hold,
  output logic                   mem_req_en,
  output logic [PADDR_WIDTH-5:0] mem_req_addr,
  input  logic                   mem_req_rdy,
  input  logic                   mem_rsp_en,
  input  logic                   mem_rsp_err,
  input  logic [127:0]           mem_rsp_data,
  output logic                   FUHit,
  output logic [REG_WIDTH-1:0]   FUreg,
  output logic [127:0]           FU_data
);

  localparam int AW = PADDR_WIDTH - 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          fifo_push, fifo_pop;
  logic [AW-1:0] push_addr, fifo_head;
  logic [CW-1:0] fifo_count;
  logic          unused_bank0_lsb;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [127:0]  data_q, data_d;
  logic          drop_q, drop_d;

  // Bank bit 0 selects a half-line; reads here are whole 16-byte units.
  assign unused_bank0_lsb = mOp_bank0[0];

  assign fifo_push = req_bus & mOp_en & (mOp_register == WALK_TAG) & ~bus_hold & ~flush;
  assign push_addr = {(mOp_odd ? mOp_addrOdd : mOp_addrEven), mOp_bank0[4:1]};
  assign fifo_pop  = (state_q == ST_IDLE) & (fifo_count != '0) & ~flush;

  ptw_req_fifo #(
    .DEPTH (DEPTH),
    .W     (AW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .push        (fifo_push),
    .push_data   (push_addr),
    .pop         (fifo_pop),
    .head        (fifo_head),
    .count       (fifo_count),
    .almost_full (bus_hold)
  );

  // Walk-read sequencing: pop, issue, wait for data, present result.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    drop_d  = drop_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fifo_pop) begin
          addr_d  = fifo_head;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (flush)            state_d = ST_IDLE;
        else if (mem_req_rdy) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // The read is already in memory; let it land but suppress the result.
        drop_d = drop_q | flush;
        if (mem_rsp_en) begin
          // Zero data clears page_na so the pager reports a not-present fault.
          data_d  = mem_rsp_err ? 128'b0 : mem_rsp_data;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        drop_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  assign mem_req_en   = (state_q == ST_ISSUE);
  assign mem_req_addr = addr_q;
  assign FUHit        = (state_q == ST_RESP) & ~drop_q;
  assign FUreg        = FUHit ? WALK_TAG : '0;
  assign FU_data      = data_q;

endmodule

// File: tb/tb_ptw_read_resp.sv
// Directed self-checking bench for ptw_read_resp.
module tb_ptw_read_resp;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         req_bus;
  logic         mOp_en;
  logic [8:0]   mOp_register;
  logic [35:0]  mOp_addrEven;
  logic [35:0]  mOp_addrOdd;
  logic         mOp_odd;
  logic [4:0]   mOp_bank0;
  logic         bus_hold;
  logic         mem_req_en;
  logic [39:0]  mem_req_addr;
  logic         mem_req_rdy;
  logic         mem_rsp_en;
  logic         mem_rsp_err;
  logic [127:0] mem_rsp_data;
  logic         FUHit;
  logic [8:0]   FUreg;
  logic [127:0] FU_data;

  int errors = 0;
  int checks = 0;
  bit overflow_seen = 1'b0;
  int max_count = 0;

  ptw_read_resp #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .req_bus      (req_bus),
    .mOp_en       (mOp_en),
    .mOp_register (mOp_register),
    .mOp_addrEven (mOp_addrEven),
    .mOp_addrOdd  (mOp_addrOdd),
    .mOp_odd      (mOp_odd),
    .mOp_bank0    (mOp_bank0),
    .bus_hold     (bus_hold),
    .mem_req_en   (mem_req_en),
    .mem_req_addr (mem_req_addr),
    .mem_req_rdy  (mem_req_rdy),
    .mem_rsp_en   (mem_rsp_en),
    .mem_rsp_err  (mem_rsp_err),
    .mem_rsp_data (mem_rsp_data),
    .FUHit        (FUHit),
    .FUreg        (FUreg),
    .FU_data      (FU_data)
  );

  always #5 clk = ~clk;

  // A push into a full FIFO must never occur.
  always @(posedge clk) begin
    if (rst && dut.fifo_push && !dut.fifo_pop && (int'(dut.fifo_count) == DEPTH))
      overflow_seen = 1'b1;
  end

  always @(negedge clk) begin
    if (int'(dut.fifo_count) > max_count) max_count = int'(dut.fifo_count);
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [8:0] tag, input logic [35:0] even, input logic [35:0] odd_line,
                          input logic sel_odd, input logic [4:0] bank0);
    req_bus      = 1'b1;
    mOp_en       = 1'b1;
    mOp_register = tag;
    mOp_addrEven = even;
    mOp_addrOdd  = odd_line;
    mOp_odd      = sel_odd;
    mOp_bank0    = bank0;
  endtask

  task automatic idle_bus();
    req_bus      = 1'b0;
    mOp_en       = 1'b0;
    mOp_register = '0;
  endtask

  // Wait for the request, accept it, answer after lat idle cycles, check the pulse.
  task automatic serve(input string tag, input logic [39:0] exp_addr, input int lat,
                       input logic [127:0] data, input logic err, input logic [127:0] exp_data);
    int n = 0;
    while (!mem_req_en && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req_en"}, mem_req_en, 1'b1);
    check({tag, "_addr"}, mem_req_addr, exp_addr);
    mem_req_rdy = 1'b1;
    tick();
    mem_req_rdy = 1'b0;
    check({tag, "_req_done"}, mem_req_en, 1'b0);
    repeat (lat) tick();
    mem_rsp_en   = 1'b1;
    mem_rsp_err  = err;
    mem_rsp_data = data;
    tick();
    mem_rsp_en   = 1'b0;
    mem_rsp_err  = 1'b0;
    check({tag, "_hit"}, FUHit, 1'b1);
    check({tag, "_reg"}, FUreg, 9'h1fc);
    check({tag, "_data"}, FU_data, exp_data);
    tick();
    check({tag, "_hit_end"}, FUHit, 1'b0);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0;
    idle_bus();
    mOp_addrEven = '0; mOp_addrOdd = '0; mOp_odd = 1'b0; mOp_bank0 = '0;
    mem_req_rdy = 1'b0; mem_rsp_en = 1'b0; mem_rsp_err = 1'b0; mem_rsp_data = '0;
    #1;
    check("rst_bus_hold", bus_hold, 1'b0);
    check("rst_req_en", mem_req_en, 1'b0);
    check("rst_req_addr", mem_req_addr, 40'h0);
    check("rst_fuhit", FUHit, 1'b0);
    check("rst_fureg", FUreg, 9'h0);
    check("rst_fudata", FU_data, 128'h0);
    check("rst_count", dut.fifo_count, 3'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Single op, response three cycles after the request is accepted.
    drive_op(9'h1fc, 36'h000012345, 36'hFFFFFFFFF, 1'b0, 5'h0A);
    tick();
    idle_bus();
    check("single_count", dut.fifo_count, 3'd1);
    serve("single", 40'h0000123455, 3, 128'hA5, 1'b0, 128'hA5);

    // Foreign tag is ignored.
    drive_op(9'h010, 36'h0ABCDEF01, 36'h0, 1'b0, 5'h02);
    tick(); tick();
    idle_bus();
    tick(); tick();
    check("tag_count", dut.fifo_count, 3'd0);
    check("tag_req_en", mem_req_en, 1'b0);

    // Back-pressure with memory stalled.
    check("bp_hold_a", bus_hold, 1'b0);
    drive_op(9'h1fc, 36'h111111111, 36'h222222222, 1'b0, 5'h03);
    tick();
    check("bp_hold_b", bus_hold, 1'b0);
    drive_op(9'h1fc, 36'h333333333, 36'h444444444, 1'b1, 5'h1F);
    tick();
    check("bp_hold_c", bus_hold, 1'b0);
    drive_op(9'h1fc, 36'h0ABCDEF01, 36'h000000000, 1'b0, 5'h10);
    tick();
    check("bp_hold_d", bus_hold, 1'b0);
    drive_op(9'h1fc, 36'h000000000, 36'hFEDCBA987, 1'b1, 5'h08);
    tick();
    check("bp_hold_set", bus_hold, 1'b1);
    check("bp_count3", dut.fifo_count, 3'd3);
    drive_op(9'h1fc, 36'h555555555, 36'h0, 1'b0, 5'h00);
    tick(); tick(); tick();
    idle_bus();
    check("bp_hold_keep", bus_hold, 1'b1);
    check("bp_count_held", dut.fifo_count, 3'd3);
    serve("bp_a", 40'h1111111111, 0, 128'h1111111111, 1'b0, 128'h1111111111);
    serve("bp_b", 40'h444444444F, 1, 128'h444444444F, 1'b0, 128'h444444444F);
    serve("bp_c", 40'h0ABCDEF018, 0, 128'h0ABCDEF018, 1'b0, 128'h0ABCDEF018);
    serve("bp_d", 40'hFEDCBA9874, 2, 128'hFEDCBA9874, 1'b0, 128'hFEDCBA9874);
    tick(); tick();
    check("bp_drained", dut.fifo_count, 3'd0);
    check("bp_no_extra", mem_req_en, 1'b0);
    check("bp_hold_clr", bus_hold, 1'b0);

    // Error response returns zero data.
    drive_op(9'h1fc, 36'h0ABCDEF01, 36'h0, 1'b0, 5'h10);
    tick();
    idle_bus();
    serve("err", 40'h0ABCDEF018, 0, 128'hFFFF, 1'b1, 128'h0);

    // Flush while a read is outstanding with two entries queued.
    drive_op(9'h1fc, 36'h111111111, 36'h222222222, 1'b0, 5'h03);
    tick();
    drive_op(9'h1fc, 36'h333333333, 36'h444444444, 1'b1, 5'h1F);
    tick();
    drive_op(9'h1fc, 36'h0ABCDEF01, 36'h0, 1'b0, 5'h10);
    tick();
    idle_bus();
    check("fl_issue", mem_req_en, 1'b1);
    mem_req_rdy = 1'b1;
    tick();
    mem_req_rdy = 1'b0;
    check("fl_count2", dut.fifo_count, 3'd2);
    flush = 1'b1;
    drive_op(9'h1fc, 36'h000000000, 36'hFEDCBA987, 1'b1, 5'h08);
    tick();
    flush = 1'b0;
    idle_bus();
    check("fl_count0", dut.fifo_count, 3'd0);
    check("fl_hold", bus_hold, 1'b0);
    mem_rsp_en = 1'b1;
    mem_rsp_data = 128'hDEAD;
    tick();
    mem_rsp_en = 1'b0;
    check("fl_no_hit", FUHit, 1'b0);
    check("fl_no_reg", FUreg, 9'h0);
    tick(); tick(); tick();
    check("fl_idle", mem_req_en, 1'b0);
    check("fl_empty", dut.fifo_count, 3'd0);

    // Reset while a request is being issued.
    drive_op(9'h1fc, 36'h111111111, 36'h0, 1'b0, 5'h03);
    tick();
    idle_bus();
    tick();
    check("rm_issue", mem_req_en, 1'b1);
    rst = 1'b0;
    #1;
    check("rm_req_en", mem_req_en, 1'b0);
    check("rm_req_addr", mem_req_addr, 40'h0);
    check("rm_fudata", FU_data, 128'h0);
    check("rm_hold", bus_hold, 1'b0);
    check("rm_count", dut.fifo_count, 3'd0);
    tick();
    rst = 1'b1;
    tick();
    mem_rsp_en = 1'b1;
    mem_rsp_data = 128'hBEEF;
    tick();
    mem_rsp_en = 1'b0;
    check("rm_no_hit", FUHit, 1'b0);
    check("rm_data_ign", FU_data, 128'h0);
    tick();
    check("rm_no_hit2", FUHit, 1'b0);
    check("rm_no_req", mem_req_en, 1'b0);

    check("no_overflow", overflow_seen, 1'b0);
    check("max_count_ok", (max_count <= DEPTH), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
